lpf_mc: RTL and testbench

Multi-channel first-order IIR low-pass filter, the parametrised successor of the single-channel `lpf` block in the control datapath. It holds filter state internally for `CH` channels and computes y[n] = y[n-1] + k·(x − y[n-1]) on a start pulse. All channels are time-multiplexed through one multiplier. Results are published atomically with a one-cycle `done` pulse; each channel can be preloaded, bypassed or masked.

---
 rtl/lpf_pkg.sv | 16 +
 rtl/lpf_mac.sv | 49 ++++
 rtl/lpf_mc.sv | 167 ++++++++++++++++
 tb/tb_lpf_mc.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lpf_pkg.sv
// Shared definitions for the multi-channel low-pass filter: controller
// state encoding and the unity-coefficient helper.
package lpf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } lpf_state_t;

    // Coefficient value that represents k = 1.0 for a given fraction width.
    function automatic int k_one(input int k_frac);
        return 1 << k_frac;
    endfunction

endpackage

// File: rtl/lpf_mac.sv
// Shared subtract / multiply / shift-add datapath. Stage one registers
// (x - state) * keff. Stage two adds the floored, scaled product back onto
// the state. All sequencing comes from the parent controller.
module lpf_mac
    import lpf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int K_W    = 16,
    parameter int K_FRAC = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic signed [DATA_W-1:0] st,
    input  logic signed [DATA_W-1:0] xin,
    input  logic        [K_W:0]      keff,
    output logic signed [DATA_W-1:0] y_new
);

    localparam int PW = DATA_W + K_W + 2;

    logic signed [DATA_W:0]   diff;
    logic signed [PW-1:0]     diff_x;
    logic signed [PW-1:0]     keff_x;
    logic signed [PW-1:0]     prod_next;
    logic signed [PW-1:0]     prod_reg;
    logic signed [DATA_W-1:0] step;

    // One extra bit keeps the difference exact for any pair of samples.
    assign diff      = {xin[DATA_W-1], xin} - {st[DATA_W-1], st};
    assign diff_x    = {{(PW-DATA_W-1){diff[DATA_W]}}, diff};
    assign keff_x    = {{(PW-K_W-1){1'b0}}, keff};
    assign prod_next = diff_x * keff_x;

    // Arithmetic shift floors toward minus infinity. Because 0 <= k <= 1 the
    // step never overshoots x, so truncation to DATA_W is lossless.
    assign step  = DATA_W'(prod_reg >>> K_FRAC);
    assign y_new = st + step;

    // Pipeline register between multiply and accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_reg <= '0;
        end else if (load) begin
            prod_reg <= prod_next;
        end
    end

endmodule

// File: rtl/lpf_mc.sv
// Multi-channel first-order IIR low-pass filter. A start pulse snapshots the
// inputs, then every channel goes through one shared multiplier (two cycles
// per channel). The visible outputs are refreshed all at once with a
// one-cycle done pulse, so they never show a half-finished run.
module lpf_mc
    import lpf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int K_W    = 16,
    parameter int K_FRAC = 15,
    parameter int CH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lpfsta,
    input  logic                 init,
    input  logic                 bypass,
    input  logic [CH-1:0]        ch_en,
    input  logic [CH*DATA_W-1:0] x,
    input  logic [CH*DATA_W-1:0] y_init,
    input  logic [K_W-1:0]       lpf_k,
    output logic [CH*DATA_W-1:0] y,
    output logic                 busy,
    output logic                 done
);

    localparam int IW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [K_W:0] K_ONE = (K_W+1)'(k_one(K_FRAC));

    lpf_state_t            fsm_reg;
    logic [IW-1:0]         idx_reg;
    logic                  phase_reg;
    logic                  done_reg;

    logic [CH*DATA_W-1:0]  x_sh_reg;
    logic [K_W-1:0]        k_sh_reg;
    logic                  byp_sh_reg;
    logic [CH-1:0]         en_sh_reg;

    logic [CH*DATA_W-1:0]  st_flat;
    logic signed [DATA_W-1:0] st_cur;
    logic signed [DATA_W-1:0] x_cur;
    logic signed [DATA_W-1:0] y_new;
    logic [K_W:0]          k_ext;
    logic [K_W:0]          keff;

    logic                  do_init;
    logic                  do_capture;
    logic                  mac_load;
    logic                  st_wr;
    logic                  do_pub;
    logic                  last_ch;

    // Control strobes decoded from the controller state.
    assign do_init    = (fsm_reg == IDLE) && init;
    assign do_capture = (fsm_reg == IDLE) && !init && lpfsta;
    assign mac_load   = (fsm_reg == CALC) && !phase_reg;
    assign st_wr      = (fsm_reg == CALC) && phase_reg;
    assign do_pub     = (fsm_reg == DONE);
    assign last_ch    = (idx_reg == IW'(CH-1));

    assign busy = (fsm_reg != IDLE);
    assign done = done_reg;

    // Coefficients above 1.0 are clamped; bypass forces exactly 1.0.
    assign k_ext = {1'b0, k_sh_reg};
    assign keff  = byp_sh_reg ? K_ONE : ((k_ext > K_ONE) ? K_ONE : k_ext);

    // Operand select for the channel currently in the datapath.
    assign st_cur = st_flat[int'(idx_reg)*DATA_W +: DATA_W];
    assign x_cur  = x_sh_reg[int'(idx_reg)*DATA_W +: DATA_W];

    lpf_mac #(
        .DATA_W (DATA_W),
        .K_W    (K_W),
        .K_FRAC (K_FRAC)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .load  (mac_load),
        .st    (st_cur),
        .xin   (x_cur),
        .keff  (keff),
        .y_new (y_new)
    );

    // Sequencer: capture shadows, walk channels in two phases, publish.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_reg    <= IDLE;
            idx_reg    <= '0;
            phase_reg  <= 1'b0;
            done_reg   <= 1'b0;
            x_sh_reg   <= '0;
            k_sh_reg   <= '0;
            byp_sh_reg <= 1'b0;
            en_sh_reg  <= '0;
        end else begin
            done_reg <= 1'b0;
            case (fsm_reg)
                IDLE: begin
                    if (do_capture) begin
                        x_sh_reg   <= x;
                        k_sh_reg   <= lpf_k;
                        byp_sh_reg <= bypass;
                        en_sh_reg  <= ch_en;
                        idx_reg    <= '0;
                        phase_reg  <= 1'b0;
                        fsm_reg    <= CALC;
                    end
                end
                CALC: begin
                    if (!phase_reg) begin
                        phase_reg <= 1'b1;
                    end else begin
                        phase_reg <= 1'b0;
                        if (last_ch) begin
                            fsm_reg <= DONE;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_reg <= 1'b1;
                    idx_reg  <= '0;
                    fsm_reg  <= IDLE;
                end
                default: fsm_reg <= IDLE;
            endcase
        end
    end

    // Per-channel filter state and published output.
    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            logic signed [DATA_W-1:0] st_reg;
            logic        [DATA_W-1:0] y_reg;

            // State: preload, or accept the datapath result on its own slot.
            always_ff @(posedge clk) begin
                if (rst) begin
                    st_reg <= '0;
                end else if (do_init) begin
                    st_reg <= y_init[gi*DATA_W +: DATA_W];
                end else if (st_wr && (idx_reg == IW'(gi)) && en_sh_reg[gi]) begin
                    st_reg <= y_new;
                end
            end

            // Output: follows a preload immediately, otherwise only on publish.
            always_ff @(posedge clk) begin
                if (rst) begin
                    y_reg <= '0;
                end else if (do_init) begin
                    y_reg <= y_init[gi*DATA_W +: DATA_W];
                end else if (do_pub) begin
                    y_reg <= st_reg;
                end
            end

            assign st_flat[gi*DATA_W +: DATA_W] = st_reg;
            assign y[gi*DATA_W +: DATA_W]       = y_reg;
        end
    endgenerate

endmodule

// File: tb/tb_lpf_mc.sv
// Directed bench for lpf_mc: step response, coefficient edges, floor
// rounding, preload/mask, start collisions and reset in the middle of a run.
module tb_lpf_mc;

    localparam int DW = 32;
    localparam int KW = 16;
    localparam int KF = 15;
    localparam int CH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            lpfsta = 1'b0;
    logic            init = 1'b0;
    logic            bypass = 1'b0;
    logic [CH-1:0]   ch_en = '0;
    logic [CH*DW-1:0] x = '0;
    logic [CH*DW-1:0] y_init = '0;
    logic [KW-1:0]   lpf_k = '0;
    logic [CH*DW-1:0] y;
    logic            busy;
    logic            done;

    int n_checks = 0;
    int n_fail   = 0;

    lpf_mc #(
        .DATA_W (DW),
        .K_W    (KW),
        .K_FRAC (KF),
        .CH     (CH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .lpfsta (lpfsta),
        .init   (init),
        .bypass (bypass),
        .ch_en  (ch_en),
        .x      (x),
        .y_init (y_init),
        .lpf_k  (lpf_k),
        .y      (y),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    function automatic logic [CH*DW-1:0] pack(input int a, input int b, input int c, input int d);
        return {d, c, b, a};
    endfunction

    function automatic int ych(input int c);
        logic signed [DW-1:0] t;
        t = y[c*DW +: DW];
        return int'(t);
    endfunction

    task automatic check_y(input string tag, input int e0, input int e1, input int e2, input int e3);
        check({tag, "_y0"}, ych(0), e0);
        check({tag, "_y1"}, ych(1), e1);
        check({tag, "_y2"}, ych(2), e2);
        check({tag, "_y3"}, ych(3), e3);
    endtask

    // Start a run and verify busy after capture, done latency, busy at done.
    task automatic run(input string tag, input logic [CH*DW-1:0] xv, input logic [KW-1:0] k,
                       input logic byp, input logic [CH-1:0] en);
        int lat;
        x = xv; lpf_k = k; bypass = byp; ch_en = en;
        lpfsta = 1'b1;
        @(posedge clk); #1;
        lpfsta = 1'b0;
        check({tag, "_busy"}, busy, 1);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (done) lat = i;
        end
        check({tag, "_lat"}, lat, 9);
        check({tag, "_busy_at_done"}, busy, 0);
    endtask

    task automatic preload(input string tag, input logic [CH*DW-1:0] v);
        y_init = v;
        init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic count_done(input int cycles, output int n, output int first);
        n = 0; first = 0;
        for (int i = 1; i <= cycles; i++) begin
            @(posedge clk); #1;
            if (done) begin
                n++;
                if (first == 0) first = i;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nd, fd;

        // Reset with a start pulse held throughout.
        rst = 1'b1; lpfsta = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; lpfsta = 1'b0;
        check_y("reset", 0, 0, 0, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        @(posedge clk); #1;
        check("reset_sta_ignored", busy, 0);

        // Step response at k = 0.5.
        run("step1", pack(1000, -2000, 3, 0), 16'h4000, 1'b0, 4'hF);
        check_y("step1", 500, -1000, 1, 0);
        run("step2", pack(1000, -2000, 3, 0), 16'h4000, 1'b0, 4'hF);
        check_y("step2", 750, -1500, 2, 0);
        run("step3", pack(1000, -2000, 3, 0), 16'h4000, 1'b0, 4'hF);
        check_y("step3", 875, -1750, 2, 0);

        // Coefficient edges.
        run("k0", pack(-1000, -1000, -1000, -1000), 16'h0000, 1'b0, 4'hF);
        check_y("k0", 875, -1750, 2, 0);
        run("k1", pack(-1000, -1000, -1000, -1000), 16'h8000, 1'b0, 4'hF);
        check_y("k1", -1000, -1000, -1000, -1000);
        preload("pre500a", pack(500, 500, 500, 500));
        check_y("pre500a", 500, 500, 500, 500);
        run("kclamp", pack(-1000, -1000, -1000, -1000), 16'hFFFF, 1'b0, 4'hF);
        check_y("kclamp", -1000, -1000, -1000, -1000);
        preload("pre500b", pack(500, 500, 500, 500));
        run("bypass", pack(-1000, -1000, -1000, -1000), 16'h0000, 1'b1, 4'hF);
        check_y("bypass", -1000, -1000, -1000, -1000);

        // Floor rounding of negative half steps.
        preload("pre0", pack(0, 0, 0, 0));
        run("floor", pack(-1, -3, 1, 5), 16'h4000, 1'b0, 4'hF);
        check_y("floor", -1, -2, 0, 2);

        // Preload then masked update.
        preload("pre100", pack(100, 100, 100, 100));
        check_y("pre100", 100, 100, 100, 100);
        run("mask", pack(300, 300, 300, 300), 16'h4000, 1'b0, 4'b0101);
        check_y("mask", 200, 100, 200, 100);

        // Start and init re-asserted while busy; inputs changed after capture.
        preload("pre0b", pack(0, 0, 0, 0));
        x = pack(1000, 1000, 1000, 1000); lpf_k = 16'h4000; bypass = 1'b0; ch_en = 4'hF;
        lpfsta = 1'b1;
        @(posedge clk); #1;
        x = pack(9999, 9999, 9999, 9999);
        y_init = pack(5, 5, 5, 5);
        init = 1'b1;
        nd = 0; fd = 0;
        for (int i = 1; i <= 25; i++) begin
            if (i == 4) begin
                lpfsta = 1'b0;
                init = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                nd++;
                if (fd == 0) fd = i;
            end
        end
        check("busy_sta_ndone", nd, 1);
        check("busy_sta_lat", fd, 9);
        check_y("busy_sta", 500, 500, 500, 500);

        // init and lpfsta together: preload only.
        y_init = pack(77, 77, 77, 77);
        init = 1'b1; lpfsta = 1'b1;
        @(posedge clk); #1;
        init = 1'b0; lpfsta = 1'b0;
        check("both_busy", busy, 0);
        check_y("both", 77, 77, 77, 77);
        count_done(12, nd, fd);
        check("both_ndone", nd, 0);
        check("both_busy_later", busy, 0);

        // Reset in the middle of a run.
        x = pack(1000, 1000, 1000, 1000); lpf_k = 16'h4000; ch_en = 4'hF;
        lpfsta = 1'b1;
        @(posedge clk); #1;
        lpfsta = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_y("midrst", 0, 0, 0, 0);
        check("midrst_busy", busy, 0);
        count_done(15, nd, fd);
        check("midrst_ndone", nd, 0);

        // Recovery after the aborted run.
        run("recover", pack(1000, -1000, 2, 4), 16'h4000, 1'b0, 4'hF);
        check_y("recover", 500, -500, 1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
